// File: rtl/framebuffer_line_fetcher_pkg.sv
// framebuffer_line_fetcher_pkg: fetch FSM states and default geometry for the ping-pong line fetcher
package framebuffer_line_fetcher_pkg;
    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQUEST,
        FETCH_STREAM,
        FETCH_DONE,
        FETCH_DRAIN
    } fetch_state_t;
    localparam int DEFAULT_LINE_PIXELS = 640;
    localparam int DEFAULT_FRAME_LINES = 480;
    localparam int DEFAULT_BLANK_PIXEL = 0;
endpackage

// File: rtl/framebuffer_line_fetcher_pixel_line_buffer.sv
// framebuffer_line_fetcher_pixel_line_buffer: two-bank 1W1R line RAM with registered read
module framebuffer_line_fetcher_pixel_line_buffer #(
    parameter int PIXEL_BITS = 12,
    parameter int LINE_PIXELS = 640,
    parameter int OFFSET_BITS = $clog2(LINE_PIXELS)
) (
    input  logic                   clock,
    input  logic                   write_enable,
    input  logic                   write_bank,
    input  logic [OFFSET_BITS-1:0] write_offset,
    input  logic [PIXEL_BITS-1:0]  write_data,
    input  logic                   read_enable,
    input  logic                   read_bank,
    input  logic [OFFSET_BITS-1:0] read_offset,
    output logic [PIXEL_BITS-1:0]  read_data
);
    logic [PIXEL_BITS-1:0] cells [2][LINE_PIXELS];
    always_ff @(posedge clock) begin
        if (write_enable) cells[write_bank][write_offset] <= write_data;
        if (read_enable) read_data <= cells[read_bank][read_offset];
    end
endmodule

// File: rtl/framebuffer_line_fetcher.sv
// framebuffer_line_fetcher: serves vga pixel reads from one line bank while burst-fetching the next line
module framebuffer_line_fetcher
    import framebuffer_line_fetcher_pkg::*;
#(
    parameter int ADDRESS_BITS = 22,
    parameter int PIXEL_BITS = 12,
    parameter int LINE_PIXELS = DEFAULT_LINE_PIXELS,
    parameter int FRAME_LINES = DEFAULT_FRAME_LINES,
    parameter logic [PIXEL_BITS-1:0] BLANK_PIXEL = PIXEL_BITS'(DEFAULT_BLANK_PIXEL)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read_enable,
    input  logic [ADDRESS_BITS-1:0] read_address,
    output logic [PIXEL_BITS-1:0]   pixel_data,
    output logic                    underrun,
    output logic                    mem_request,
    output logic [ADDRESS_BITS-1:0] mem_address,
    input  logic                    mem_grant,
    input  logic                    mem_data_valid,
    input  logic [PIXEL_BITS-1:0]   mem_data
);
    localparam int FRAME_PIXELS = LINE_PIXELS * FRAME_LINES;
    localparam int BEAT_BITS = $clog2(LINE_PIXELS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_PIXELS - 1);
    localparam logic [ADDRESS_BITS-1:0] LINE_SPAN = ADDRESS_BITS'(LINE_PIXELS);
    localparam logic [ADDRESS_BITS-1:0] LAST_LINE_BASE = ADDRESS_BITS'(FRAME_PIXELS - LINE_PIXELS);

    function automatic logic [ADDRESS_BITS-1:0] line_after(input logic [ADDRESS_BITS-1:0] base);
        logic [ADDRESS_BITS-1:0] sum;
        sum = base + LINE_SPAN;
        return (sum == ADDRESS_BITS'(FRAME_PIXELS)) ? '0 : sum;
    endfunction

    fetch_state_t state, state_next;
    logic [ADDRESS_BITS-1:0] line_base, next_base, after_next, fetch_target, line_offset;
    logic [BEAT_BITS-1:0] beat_count;
    logic [PIXEL_BITS-1:0] buffer_data;
    logic active_bank, active_valid, pixel_select, request_pause;
    logic fill_ready, write_enable, granted, last_beat, advance, swap, abandon, hit;

    assign next_base = line_after(line_base);
    assign after_next = line_after(next_base);
    assign line_offset = read_address - line_base;
    assign advance = read_enable && read_address == next_base;
    assign hit = read_enable && active_valid && line_offset < LINE_SPAN;
    assign last_beat = state == FETCH_STREAM && mem_data_valid && beat_count == LAST_BEAT;
    // a final beat landing on the boundary cycle completes the line in time
    assign swap = advance && (fill_ready || last_beat);
    assign abandon = advance && !swap;
    assign granted = mem_request && mem_grant;
    assign fetch_target = advance ? after_next : next_base;
    assign pixel_data = pixel_select ? buffer_data : BLANK_PIXEL;

    framebuffer_line_fetcher_pixel_line_buffer #(
        .PIXEL_BITS(PIXEL_BITS),
        .LINE_PIXELS(LINE_PIXELS),
        .OFFSET_BITS(BEAT_BITS)
    ) line_buffer (
        .clock(clock),
        .write_enable(write_enable),
        .write_bank(~active_bank),
        .write_offset(beat_count),
        .write_data(mem_data),
        .read_enable(hit || swap),
        .read_bank(swap ? ~active_bank : active_bank),
        .read_offset(swap ? '0 : line_offset[BEAT_BITS-1:0]),
        .read_data(buffer_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            line_base <= LAST_LINE_BASE;
            active_bank <= 1'b0;
            active_valid <= 1'b0;
            pixel_select <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= abandon;
            if (read_enable) pixel_select <= hit || swap;
            if (advance) line_base <= next_base;
            if (swap) begin
                active_bank <= ~active_bank;
                active_valid <= 1'b1;
            end else if (abandon) begin
                active_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        state <= reset ? FETCH_IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE:    state_next = FETCH_REQUEST;
            FETCH_REQUEST: state_next = granted ? (abandon ? FETCH_DRAIN : FETCH_STREAM) : FETCH_REQUEST;
            FETCH_STREAM:  state_next = swap ? FETCH_IDLE : abandon ? FETCH_DRAIN : last_beat ? FETCH_DONE : FETCH_STREAM;
            FETCH_DONE:    state_next = swap ? FETCH_IDLE : FETCH_DONE;
            FETCH_DRAIN:   state_next = (mem_data_valid && beat_count == LAST_BEAT) ? FETCH_IDLE : FETCH_DRAIN;
            default:       state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        mem_request = state == FETCH_REQUEST && !request_pause;
        fill_ready = state == FETCH_DONE;
        write_enable = state == FETCH_STREAM && mem_data_valid && !abandon;
    end

    // an ungranted request is retargeted with a one-cycle gap so the address never moves under a live request
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            beat_count <= '0;
            request_pause <= 1'b0;
        end else begin
            request_pause <= state == FETCH_REQUEST && abandon && !granted;
            if (state == FETCH_IDLE || (state == FETCH_REQUEST && abandon && !granted)) mem_address <= fetch_target;
            if (granted) beat_count <= '0;
            else if (mem_data_valid && (state == FETCH_STREAM || state == FETCH_DRAIN)) beat_count <= beat_count + BEAT_BITS'(1);
        end
    end
endmodule

// File: tb/tb_framebuffer_line_fetcher.sv
// tb_framebuffer_line_fetcher: scoreboard bench with a burst memory model driving the line fetcher
module tb_framebuffer_line_fetcher;
    localparam int AB = 22;
    localparam int PB = 12;
    localparam int LINE = 640;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic read_enable = 1'b0;
    logic [AB-1:0] read_address = '0;
    logic [PB-1:0] pixel_data;
    logic underrun, mem_request;
    logic [AB-1:0] mem_address;
    logic mem_grant = 1'b0;
    logic mem_data_valid = 1'b0;
    logic [PB-1:0] mem_data = '0;

    int total = 0;
    int bad = 0;
    int underrun_count = 0;
    int beat_idx = 0;
    int bursts_done = 0;
    logic burst = 1'b0;
    logic allow_grant = 1'b0;
    logic read_seen = 1'b0;
    logic [AB-1:0] burst_addr = '0;
    logic [AB-1:0] grant_hold = '0;
    logic [PB-1:0] exp_q[$];
    logic [AB-1:0] grant_q[$];

    always #5 clock = ~clock;

    framebuffer_line_fetcher dut (
        .clock(clock),
        .reset(reset),
        .read_enable(read_enable),
        .read_address(read_address),
        .pixel_data(pixel_data),
        .underrun(underrun),
        .mem_request(mem_request),
        .mem_address(mem_address),
        .mem_grant(mem_grant),
        .mem_data_valid(mem_data_valid),
        .mem_data(mem_data)
    );

    function automatic logic [PB-1:0] pix(input logic [AB-1:0] a);
        return PB'(a ^ (a >> 12));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    always @(posedge clock) read_seen <= read_enable && !reset;

    always @(negedge clock) begin
        if (underrun === 1'b1) underrun_count++;
        if (read_seen) begin
            if (exp_q.size() == 0) check("scoreboard_size", exp_q.size(), 1);
            else check("pixel", pixel_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        read_enable = 1'b0;
        if (reset) begin
            burst = 1'b0;
            beat_idx = 0;
            mem_grant = 1'b0;
            mem_data_valid = 1'b0;
        end else begin
            if (mem_data_valid) begin
                beat_idx++;
                if (beat_idx == LINE) begin
                    burst = 1'b0;
                    bursts_done++;
                end
            end
            if (mem_grant) begin
                burst = 1'b1;
                beat_idx = 0;
                burst_addr = grant_hold;
                grant_q.push_back(grant_hold);
            end
            mem_grant = !burst && !mem_grant && allow_grant && mem_request;
            if (mem_grant) grant_hold = mem_address;
            mem_data_valid = burst && beat_idx < LINE;
            mem_data = pix(burst_addr + AB'(beat_idx));
        end
    endtask

    task automatic drive_read(input logic [AB-1:0] a, input logic [PB-1:0] e);
        read_enable = 1'b1;
        read_address = a;
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [AB-1:0] a, input logic [PB-1:0] e);
        tick();
        drive_read(a, e);
    endtask

    task automatic wait_burst(input int limit);
        int start = bursts_done;
        int n = 0;
        while (bursts_done == start && n < limit) begin
            tick();
            n++;
        end
        if (bursts_done == start) check("burst_timeout", bursts_done - start, 1);
    endtask

    task automatic expect_grant(input logic [AB-1:0] want, input int limit);
        int n = 0;
        while (grant_q.size() == 0 && n < limit) begin
            tick();
            n++;
        end
        if (grant_q.size() == 0) check("grant_timeout", grant_q.size(), 1);
        else check("grant_address", grant_q.pop_front(), want);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_pixel", pixel_data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_request", mem_request, 0);
        check("rst_address", mem_address, 0);
        reset = 1'b0;
        allow_grant = 1'b1;
        expect_grant(0, 50);
        wait_burst(2000);
        tick();
        check("done_request_low", mem_request, 0);
        allow_grant = 1'b0;
        for (int a = 0; a < LINE; a++) rd(AB'(a), pix(AB'(a)));
        tick();
        tick();
        check("next_request", mem_request, 1);
        check("next_address", mem_address, 640);
        check("underrun_none", underrun_count, 0);
        for (int a = 640; a < 1280; a++) rd(AB'(a), '0);
        tick();
        tick();
        check("underrun_once", underrun_count, 1);
        check("refetch_address", mem_address, 1280);
        allow_grant = 1'b1;
        expect_grant(1280, 50);
        n = 0;
        tick();
        while (!(mem_data_valid && beat_idx == LINE - 1) && n < 2000) begin
            tick();
            n++;
        end
        check("last_beat_seen", mem_data_valid && beat_idx == LINE - 1, 1);
        allow_grant = 1'b0;
        drive_read(1280, pix(1280));
        rd(1281, pix(1281));
        rd(1919, pix(1919));
        tick();
        tick();
        check("no_underrun_last_beat", underrun_count, 1);
        for (int a = 1920; a <= 305920; a += 640) rd(AB'(a), '0);
        rd(305930, '0);
        tick();
        tick();
        check("underrun_many", underrun_count, 477);
        check("last_line_address", mem_address, 306560);
        allow_grant = 1'b1;
        expect_grant(306560, 50);
        wait_burst(2000);
        rd(306560, pix(306560));
        rd(307199, pix(307199));
        expect_grant(0, 50);
        wait_burst(2000);
        rd(0, pix(0));
        rd(639, pix(639));
        rd(12345, '0);
        rd(1, pix(1));
        expect_grant(640, 50);
        n = 0;
        while (!(mem_data_valid && beat_idx == 300) && n < 2000) begin
            tick();
            n++;
        end
        check("beat_300_seen", mem_data_valid && beat_idx == 300, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_pixel", pixel_data, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_request", mem_request, 0);
        check("mid_rst_address", mem_address, 0);
        reset = 1'b0;
        expect_grant(0, 50);
        wait_burst(2000);
        rd(0, pix(0));
        rd(2, pix(2));
        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
